// File: rtl/serial_addsub_digit_pkg.sv
// Shared types and helpers for the digit-serial add/subtract datapath.
package serial_arith_pkg;

   typedef enum logic {OP_ADD = 1'b0, OP_SUB = 1'b1} op_e;
   typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_e;

   function automatic int unsigned cnt_width(input int unsigned n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/serial_addsub_digit_adder.sv
// Combinational DIGIT_W-bit ripple adder built from explicit full-adder cells.
module digit_adder #(
   parameter int unsigned DIGIT_W = 4
) (
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   input  logic               cin,
   output logic [DIGIT_W-1:0] s,
   output logic               cout,
   output logic               c_msb_in
);

   logic [DIGIT_W:0] c;

   always_comb begin
      c    = '0;
      s    = '0;
      c[0] = cin;
      for (int unsigned i = 0; i < DIGIT_W; i++) begin
         s[i]   = a[i] ^ b[i] ^ c[i];
         c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
      end
   end

   assign cout     = c[DIGIT_W];
   assign c_msb_in = c[DIGIT_W-1];

endmodule

// File: rtl/serial_addsub_digit.sv
// Digit-serial add/subtract, LSB digit first, with word framing and end-of-word flags.
module serial_addsub_digit
   import serial_arith_pkg::*;
#(
   parameter int unsigned DIGIT_W  = 4,
   parameter int unsigned N_DIGITS = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   input  logic               in_first,
   input  logic               in_sub,
   input  logic [DIGIT_W-1:0] a,
   input  logic [DIGIT_W-1:0] b,
   output logic               out_valid,
   output logic [DIGIT_W-1:0] out_sum,
   output logic               out_last,
   output logic               out_carry,
   output logic               out_ovf
);

   localparam int unsigned CW = cnt_width(N_DIGITS);
   localparam logic [CW-1:0] LAST_IDX = CW'(N_DIGITS - 1);

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic               carry_q, carry_d;
   op_e                op_q, op_d;
   logic               out_valid_q, out_valid_d;
   logic [DIGIT_W-1:0] out_sum_q, out_sum_d;
   logic               out_last_q, out_last_d;
   logic               out_carry_q, out_carry_d;
   logic               out_ovf_q, out_ovf_d;

   logic               accept;
   op_e                op_cur;
   logic               cin;
   logic [CW-1:0]      idx;
   logic [DIGIT_W-1:0] b_eff;
   logic [DIGIT_W-1:0] s;
   logic               cout;
   logic               c_msb_in;

   // A first beat always starts a fresh word, aborting any word still in flight.
   always_comb begin
      accept = in_valid & (in_first | (state_q == S_BUSY));
      op_cur = in_first ? op_e'(in_sub) : op_q;
      cin    = in_first ? in_sub : carry_q;
      idx    = in_first ? '0 : cnt_q;
      b_eff  = (op_cur == OP_SUB) ? ~b : b;
   end

   digit_adder #(.DIGIT_W(DIGIT_W)) u_adder (
      .a        (a),
      .b        (b_eff),
      .cin      (cin),
      .s        (s),
      .cout     (cout),
      .c_msb_in (c_msb_in)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      carry_d     = carry_q;
      op_d        = op_q;
      out_valid_d = 1'b0;
      out_sum_d   = out_sum_q;
      out_last_d  = out_last_q;
      out_carry_d = out_carry_q;
      out_ovf_d   = out_ovf_q;
      if (accept) begin
         out_valid_d = 1'b1;
         out_sum_d   = s;
         op_d        = op_cur;
         if (idx == LAST_IDX) begin
            out_last_d  = 1'b1;
            out_carry_d = cout;
            out_ovf_d   = c_msb_in ^ cout;
            state_d     = S_IDLE;
            cnt_d       = '0;
            carry_d     = 1'b0;
         end else begin
            out_last_d  = 1'b0;
            out_carry_d = 1'b0;
            out_ovf_d   = 1'b0;
            state_d     = S_BUSY;
            cnt_d       = idx + CW'(1);
            carry_d     = cout;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         carry_q     <= 1'b0;
         op_q        <= OP_ADD;
         out_valid_q <= 1'b0;
         out_sum_q   <= '0;
         out_last_q  <= 1'b0;
         out_carry_q <= 1'b0;
         out_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         carry_q     <= carry_d;
         op_q        <= op_d;
         out_valid_q <= out_valid_d;
         out_sum_q   <= out_sum_d;
         out_last_q  <= out_last_d;
         out_carry_q <= out_carry_d;
         out_ovf_q   <= out_ovf_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_sum   = out_sum_q;
   assign out_last  = out_last_q;
   assign out_carry = out_carry_q;
   assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_serial_addsub_digit.sv
// Scoreboard bench: one bit-serial instance and one default 4-bit-digit instance.
module tb_serial_addsub_digit;

   typedef struct {
      logic [3:0] sum;
      logic       last;
      logic       carry;
      logic       ovf;
      int         cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   exp_t q1[$];
   exp_t q4[$];

   logic       v1 = 1'b0, f1 = 1'b0, s1 = 1'b0;
   logic [0:0] a1 = '0, b1 = '0;
   logic       o1_valid, o1_last, o1_carry, o1_ovf;
   logic [0:0] o1_sum;

   logic       v4 = 1'b0, f4 = 1'b0, s4 = 1'b0;
   logic [3:0] a4 = '0, b4 = '0;
   logic       o4_valid, o4_last, o4_carry, o4_ovf;
   logic [3:0] o4_sum;

   serial_addsub_digit #(.DIGIT_W(1), .N_DIGITS(4)) dut1 (
      .clk(clk), .rst(rst), .in_valid(v1), .in_first(f1), .in_sub(s1), .a(a1), .b(b1),
      .out_valid(o1_valid), .out_sum(o1_sum), .out_last(o1_last),
      .out_carry(o1_carry), .out_ovf(o1_ovf));

   serial_addsub_digit dut4 (
      .clk(clk), .rst(rst), .in_valid(v4), .in_first(f4), .in_sub(s4), .a(a4), .b(b4),
      .out_valid(o4_valid), .out_sum(o4_sum), .out_last(o4_last),
      .out_carry(o4_carry), .out_ovf(o4_ovf));

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // Monitor: pop one expectation per presented digit, including its cycle.
   always @(negedge clk) begin
      exp_t e;
      if (rst && o1_valid) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL d1_unexpected cyc=%0d got sum=%0d last=%0b", cyc, o1_sum, o1_last);
         end else begin
            e = q1.pop_front();
            if ({3'b000, o1_sum} !== e.sum || o1_last !== e.last || o1_carry !== e.carry ||
                o1_ovf !== e.ovf || cyc != e.cyc) begin
               errors++;
               $display("FAIL d1_digit got sum=%0h last=%0b carry=%0b ovf=%0b cyc=%0d want sum=%0h last=%0b carry=%0b ovf=%0b cyc=%0d",
                        o1_sum, o1_last, o1_carry, o1_ovf, cyc, e.sum, e.last, e.carry, e.ovf, e.cyc);
            end
         end
      end
      if (rst && o4_valid) begin
         checks++;
         if (q4.size() == 0) begin
            errors++;
            $display("FAIL d4_unexpected cyc=%0d got sum=%0h last=%0b", cyc, o4_sum, o4_last);
         end else begin
            e = q4.pop_front();
            if (o4_sum !== e.sum || o4_last !== e.last || o4_carry !== e.carry ||
                o4_ovf !== e.ovf || cyc != e.cyc) begin
               errors++;
               $display("FAIL d4_digit got sum=%0h last=%0b carry=%0b ovf=%0b cyc=%0d want sum=%0h last=%0b carry=%0b ovf=%0b cyc=%0d",
                        o4_sum, o4_last, o4_carry, o4_ovf, cyc, e.sum, e.last, e.carry, e.ovf, e.cyc);
            end
         end
      end
   end

   task automatic drive(input int unit, input logic v, input logic f, input logic sub,
                        input logic [3:0] aa, input logic [3:0] bb);
      @(negedge clk);
      v1 = 1'b0; v4 = 1'b0;
      if (unit == 1) begin
         v1 = v; f1 = f; s1 = sub; a1 = aa[0:0]; b1 = bb[0:0];
      end else begin
         v4 = v; f4 = f; s4 = sub; a4 = aa; b4 = bb;
      end
   endtask

   task automatic beat(input int unit, input logic f, input logic sub,
                       input logic [3:0] aa, input logic [3:0] bb,
                       input logic [3:0] esum, input logic elast,
                       input logic ecarry, input logic eovf);
      exp_t e;
      drive(unit, 1'b1, f, sub, aa, bb);
      e.sum = esum; e.last = elast; e.carry = ecarry; e.ovf = eovf; e.cyc = cyc + 1;
      if (unit == 1) q1.push_back(e);
      else q4.push_back(e);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         v1 = 1'b0; v4 = 1'b0;
      end
   endtask

   task automatic check_zero(input string name);
      checks++;
      if ({o1_valid, o1_sum, o1_last, o1_carry, o1_ovf,
           o4_valid, o4_sum, o4_last, o4_carry, o4_ovf} !== '0) begin
         errors++;
         $display("FAIL %s got d1=%b%b%b%b%b d4=%b%h%b%b%b want all zero", name,
                  o1_valid, o1_sum, o1_last, o1_carry, o1_ovf,
                  o4_valid, o4_sum, o4_last, o4_carry, o4_ovf);
      end
   endtask

   initial begin
      repeat (2) @(negedge clk);
      #1 check_zero("reset_state");
      @(negedge clk);
      rst = 1'b1;

      // bit-serial 5+3 and 3-5
      beat(1, 1, 0, 4'h1, 4'h1, 4'h0, 0, 0, 0);
      beat(1, 0, 0, 4'h0, 4'h1, 4'h0, 0, 0, 0);
      beat(1, 0, 0, 4'h1, 4'h0, 4'h0, 0, 0, 0);
      beat(1, 0, 0, 4'h0, 4'h0, 4'h1, 1, 0, 1);
      beat(1, 1, 1, 4'h1, 4'h1, 4'h0, 0, 0, 0);
      beat(1, 0, 0, 4'h1, 4'h0, 4'h1, 0, 0, 0);
      beat(1, 0, 0, 4'h0, 4'h1, 4'h1, 0, 0, 0);
      beat(1, 0, 0, 4'h0, 4'h0, 4'h1, 1, 0, 0);
      // bit-serial abort on the last expected index, then 5+3 again
      beat(1, 1, 0, 4'h1, 4'h0, 4'h1, 0, 0, 0);
      beat(1, 0, 0, 4'h1, 4'h0, 4'h1, 0, 0, 0);
      beat(1, 0, 0, 4'h1, 4'h0, 4'h1, 0, 0, 0);
      beat(1, 1, 0, 4'h1, 4'h1, 4'h0, 0, 0, 0);
      beat(1, 0, 0, 4'h0, 4'h1, 4'h0, 0, 0, 0);
      beat(1, 0, 0, 4'h1, 4'h0, 4'h0, 0, 0, 0);
      beat(1, 0, 0, 4'h0, 4'h0, 4'h1, 1, 0, 1);

      // 0xFFFF + 0x0001, 0x7FFF + 0x0001
      beat(4, 1, 0, 4'hF, 4'h1, 4'h0, 0, 0, 0);
      beat(4, 0, 0, 4'hF, 4'h0, 4'h0, 0, 0, 0);
      beat(4, 0, 0, 4'hF, 4'h0, 4'h0, 0, 0, 0);
      beat(4, 0, 0, 4'hF, 4'h0, 4'h0, 1, 1, 0);
      beat(4, 1, 0, 4'hF, 4'h1, 4'h0, 0, 0, 0);
      beat(4, 0, 0, 4'hF, 4'h0, 4'h0, 0, 0, 0);
      beat(4, 0, 0, 4'hF, 4'h0, 4'h0, 0, 0, 0);
      beat(4, 0, 0, 4'h7, 4'h0, 4'h8, 1, 0, 1);
      // 0x1234 + 0x1111 with gaps 0, 3, 1
      beat(4, 1, 0, 4'h4, 4'h1, 4'h5, 0, 0, 0);
      beat(4, 0, 0, 4'h3, 4'h1, 4'h4, 0, 0, 0);
      idle(3);
      beat(4, 0, 0, 4'h2, 4'h1, 4'h3, 0, 0, 0);
      idle(1);
      beat(4, 0, 0, 4'h1, 4'h1, 4'h2, 1, 0, 0);
      // abort after 2 digits, then 0x0001 - 0x0001, then a stray beat in IDLE
      beat(4, 1, 0, 4'h9, 4'h9, 4'h2, 0, 0, 0);
      beat(4, 0, 0, 4'h1, 4'h0, 4'h2, 0, 0, 0);
      beat(4, 1, 1, 4'h1, 4'h1, 4'h0, 0, 0, 0);
      beat(4, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
      beat(4, 0, 0, 4'h0, 4'h0, 4'h0, 0, 0, 0);
      beat(4, 0, 0, 4'h0, 4'h0, 4'h0, 1, 1, 0);
      drive(4, 1, 0, 0, 4'h3, 4'h3);
      idle(2);

      // reset mid-word: outputs clear asynchronously
      beat(4, 1, 0, 4'h4, 4'h1, 4'h5, 0, 0, 0);
      beat(4, 0, 0, 4'h3, 4'h1, 4'h4, 0, 0, 0);
      @(negedge clk);
      v4 = 1'b0;
      #2 rst = 1'b0;
      #1 check_zero("async_reset");
      @(negedge clk);
      rst = 1'b1;
      drive(4, 1, 0, 0, 4'h2, 4'h1);
      drive(4, 1, 0, 0, 4'h1, 4'h1);
      beat(4, 1, 0, 4'h4, 4'h1, 4'h5, 0, 0, 0);
      beat(4, 0, 0, 4'h3, 4'h1, 4'h4, 0, 0, 0);
      beat(4, 0, 0, 4'h2, 4'h1, 4'h3, 0, 0, 0);
      beat(4, 0, 0, 4'h1, 4'h1, 4'h2, 1, 0, 0);
      idle(4);

      checks++;
      if (q1.size() != 0 || q4.size() != 0) begin
         errors++;
         $display("FAIL missing_outputs got pending d1=%0d d4=%0d want 0", q1.size(), q4.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/serial_addsub_digit.md
Name: serial_addsub_digit

Overview:
Parametrised digit-serial adder/subtractor: consumes two operands LSB-digit-first, DIGIT_W bits per accepted beat, over N_DIGITS beats per word. Adds over the single-bit serial adder: selectable add/subtract per word, word framing with first/last markers, valid-qualified beats with gaps allowed, and end-of-word carry-out and signed-overflow flags. Sits in the serial arithmetic datapath between a serialiser and a result deserialiser.

Parameters:
DIGIT_W, 4, bits per digit (>=1)
N_DIGITS, 4, digits per word (>=2); word width W = DIGIT_W*N_DIGITS

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset
in_valid  in  1  beat qualifier for a, b, in_first, in_sub
in_first  in  1  beat is digit 0 (LSB) of a new word
in_sub  in  1  op for word, sampled only on first beat: 0 = a+b, 1 = a-b
a  in  DIGIT_W  operand A digit
b  in  DIGIT_W  operand B digit
out_valid  out  1  result digit valid
out_sum  out  DIGIT_W  result digit
out_last  out  1  out_sum is the MSB digit of the word
out_carry  out  1  carry-out of MSB, valid only with out_last (sub: 1 = no borrow)
out_ovf  out  1  two's-complement overflow, valid only with out_last

Behaviour:
- Reset (rst=0, async): state IDLE, digit counter 0, carry 0, op ADD; out_valid, out_sum, out_last, out_carry, out_ovf all 0.
- States: IDLE (no word in flight), BUSY (counter holds index of next expected digit, 1..N_DIGITS-1).
- Accepted beat: in_valid=1 and (in_first=1, or state BUSY). In IDLE, in_valid=1 with in_first=0 is dropped; no output.
- First beat: latch op = in_sub; carry_in = in_sub (not the stored carry); b_eff = sub ? ~b : b.
- Later beats: carry_in = stored carry, op = latched op.
- Digit sum: {c_out, s} = a + b_eff + carry_in at DIGIT_W+1 bits; c_msb_in = carry into bit DIGIT_W-1 of the digit.
- Outputs are registered, latency 1: beat accepted at edge k -> out_valid=1 with out_sum = s after edge k; out_valid=0 after any edge with no accepted beat. Other outputs hold their last value while out_valid=0.
- Carry register <= c_out on each accepted beat; held on in_valid=0 (gaps of any length allowed, no timeout).
- Counter: increments per accepted beat. On digit N_DIGITS-1: out_last=1, out_carry=c_out, out_ovf=c_msb_in XOR c_out; state -> IDLE, counter 0, carry 0. Otherwise out_last, out_carry, out_ovf = 0.
- in_first=1 while BUSY: current word aborted without out_last; beat treated as digit 0 of a new word (carry and op re-initialised, counter 1).
- in_first=1 on the last expected digit index: abort rule applies; the beat is digit 0 of the new word.
- Reset asserted mid-word: word discarded, all state as reset; first post-reset output only follows a new in_first beat.
- No backpressure: one beat per cycle is always accepted.

Decomposition:
- Package serial_arith_pkg: typedef enum op_e {OP_ADD=0, OP_SUB=1}; typedef enum state_e {S_IDLE, S_BUSY}; function clog2-based counter width helper.
- Sub-module digit_adder (combinational, parameter DIGIT_W): inputs a, b, cin; outputs s, cout, c_msb_in. Built as a ripple chain of AND/OR/XOR full-adder cells, no '+' operator, so DIGIT_W=1 reduces to the single-bit serial adder.

Test Plan:
- DIGIT_W=1, N_DIGITS=4, add 5+3: a digits 1,0,1,0 / b 1,1,0,0 LSB-first, back-to-back -> out_sum 0,0,0,1; out_last on 4th; out_carry=0, out_ovf=1.
- DIGIT_W=1, N_DIGITS=4, sub 3-5 (in_sub=1 on first beat) -> out_sum 0,1,1,1 (0xE); out_carry=0, out_ovf=0.
- Defaults, add 0xFFFF+0x0001 -> digits F,F,F,F + 1,0,0,0 -> out_sum 0,0,0,0; out_carry=1, out_ovf=0. Then 0x7FFF+0x0001 -> 0,0,0,8; out_carry=0, out_ovf=1.
- Defaults, 0x1234+0x1111 with in_valid=0 gaps of 0, 3, and 1 cycles between beats -> out_sum 5,4,3,2, each 1 cycle after its beat; out_valid=0 during gaps; carry held.
- Restart: 2 digits of a word, then in_first=1 new word 0x0001-0x0001 -> no out_last for aborted word; new word out_sum 0,0,0,0, out_carry=1, out_ovf=0. Stray in_valid without in_first in IDLE -> no output.
- Pull rst low mid-word after 2 digits -> all outputs 0 immediately (async); after release, beats without in_first dropped; next full word correct.
